shift_frame_sequencer: RTL and testbench

Control stage that sits directly upstream of the universal shift register and drives its control and load pins. It accepts one parallel word per transaction over a valid/ready handshake, then issues one load strobe followed by a programmed number of single-bit shift strobes in a chosen direction. Optional idle gap cycles can be inserted between shifts. A done pulse marks the end of each frame.

---
 rtl/shift_frame_sequencer_if.sv | 49 ++++
 rtl/shift_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_shift_frame_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_sequencer_if
// Description : Request handshake and shift-register control bundle between
//               a word source, the shift frame sequencer and the downstream
//               universal shift register.
//   Request side  : in_valid, in_ready, in_data, in_dir, in_len, in_gap,
//                   in_fill, abort
//   Control side  : load_en, shift_en, left_en, right_en, load_data,
//                   fill_out, busy, done
//   Modports      : master = request source / control consumer,
//                   slave  = sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_frame_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int GAP_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_dir;
  logic [CNT_WIDTH-1:0]  in_len;
  logic [GAP_WIDTH-1:0]  in_gap;
  logic                  in_fill;
  logic                  abort;
  logic                  load_en;
  logic                  shift_en;
  logic                  left_en;
  logic                  right_en;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  fill_out;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid, in_data, in_dir, in_len, in_gap, in_fill, abort,
    input  in_ready, load_en, shift_en, left_en, right_en, load_data,
           fill_out, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_len, in_gap, in_fill, abort,
    output in_ready, load_en, shift_en, left_en, right_en, load_data,
           fill_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_sequencer
// Description : Accepts one parallel word per valid/ready transaction, then
//               issues one load strobe followed by a programmed number of
//               single-bit shift strobes (optionally separated by idle gap
//               cycles) toward a universal shift register. A one-cycle done
//               pulse closes each normally completed frame.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request handshake and shift-register control (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_frame_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int GAP_WIDTH  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  shift_frame_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] C_FULL_LEN = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] C_GAP_ONE  = GAP_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  dir_q,     dir_d;
  logic                  fill_q,    fill_d;
  logic [GAP_WIDTH-1:0]  gap_q,     gap_d;
  logic [CNT_WIDTH-1:0]  len_q,     len_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;

  logic [CNT_WIDTH-1:0]  len_eff;

  // Zero requests a full-word frame; anything beyond the word width is
  // clamped so the frame never shifts more bits than the register holds.
  always_comb begin
    len_eff = bus.in_len;
    if ((bus.in_len == '0) || (bus.in_len > C_FULL_LEN)) begin
      len_eff = C_FULL_LEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
      gap_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      fill_q    <= fill_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    gap_d     = gap_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort is deliberately not looked at here: a request arriving
        // together with abort is still accepted.
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          dir_d   = bus.in_dir;
          gap_d   = bus.in_gap;
          fill_d  = bus.in_fill;
          len_d   = len_eff;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = len_q;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = ST_DONE;
        end else if (gap_q != '0) begin
          gap_cnt_d = gap_q;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - C_GAP_ONE;
        if (gap_cnt_q == C_GAP_ONE) begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over every frame transition; the strobe already decoded
    // from the current state still goes out this cycle.
    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d = ST_IDLE;
    end
  end

  // All outputs are pure decodes of registered state.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.load_en   = (state_q == ST_LOAD);
  assign bus.shift_en  = (state_q == ST_SHIFT);
  assign bus.left_en   = (state_q == ST_SHIFT) && !dir_q;
  assign bus.right_en  = (state_q == ST_SHIFT) &&  dir_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.load_data = (state_q != ST_IDLE) ? data_q : '0;
  assign bus.fill_out  = (state_q != ST_IDLE) && fill_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_frame_sequencer
// Description : Directed self-checking bench for shift_frame_sequencer with a
//               reference model of the downstream shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_frame_sequencer;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int GW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  shift_frame_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)) sif ();

  shift_frame_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shift register model and event logs, sampled mid-cycle.
  logic [DW-1:0] sr = '0;
  int n_load = 0, n_shift = 0, n_done = 0, n_viol = 0, n_right = 0;
  int load_log [0:255];
  int shift_log[0:255];
  int done_log [0:255];

  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.load_en) begin
        sr <= sif.load_data;
        load_log[n_load & 255] <= cyc;
        n_load <= n_load + 1;
      end else if (sif.shift_en) begin
        sr <= sif.left_en ? {sr[DW-2:0], sif.fill_out} : {sif.fill_out, sr[DW-1:1]};
        shift_log[n_shift & 255] <= cyc;
        n_shift <= n_shift + 1;
        n_right <= n_right + (sif.right_en ? 1 : 0);
      end
      if (sif.done) begin
        done_log[n_done & 255] <= cyc;
        n_done <= n_done + 1;
      end
      n_viol <= n_viol
              + ((sif.shift_en && (sif.left_en == sif.right_en)) ? 1 : 0)
              + ((!sif.shift_en && (sif.left_en || sif.right_en)) ? 1 : 0)
              + ((sif.load_en && sif.shift_en) ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, takes the accept edge and leaves the bench in
  // cycle 1 of the frame. Returns the cycle base so that cyc - base is the
  // frame-relative cycle number.
  task automatic start(input logic [DW-1:0] d, input logic dir, input logic [CW-1:0] len,
                       input logic [GW-1:0] gap, input logic fill, output int base);
    sif.in_data  = d;
    sif.in_dir   = dir;
    sif.in_len   = len;
    sif.in_gap   = gap;
    sif.in_fill  = fill;
    sif.in_valid = 1'b1;
    base = cyc;
    tick();
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int seen_cyc);
    seen_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      if (sif.done) begin
        seen_cyc = cyc;
        break;
      end
      tick();
    end
    if (seen_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base, dcyc, s0, r0, d0, l0;

    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    sif.in_dir   = 1'b0;
    sif.in_len   = '0;
    sif.in_gap   = '0;
    sif.in_fill  = 1'b0;
    sif.abort    = 1'b0;

    // Reset then idle
    #1;
    check("rst_async_ready", 32'(sif.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(sif.in_ready), 32'd1);
    check("idle_strobes", 32'({sif.load_en, sif.shift_en, sif.left_en, sif.right_en,
                              sif.busy, sif.done, sif.fill_out}), 32'd0);
    check("idle_load_data", 32'(sif.load_data), 32'd0);

    // Basic left frame: A5, len 3, gap 0, fill 0
    s0 = n_shift;
    start(8'hA5, 1'b0, 4'd3, 4'd0, 1'b0, base);
    check("left_load_en", 32'(sif.load_en), 32'd1);
    check("left_load_data", 32'(sif.load_data), 32'hA5);
    check("left_busy_ready", 32'({sif.busy, sif.in_ready}), 32'b10);
    tick();
    check("left_shift_dir", 32'({sif.shift_en, sif.left_en, sif.right_en}), 32'b110);
    wait_done(20, dcyc);
    check("left_done_cycle", 32'(dcyc - base), 32'd5);
    tick();
    check("left_ready_after", 32'({sif.in_ready, sif.busy, sif.load_data}), {1'b1, 1'b0, 8'h00});
    check("left_shift_count", 32'(n_shift - s0), 32'd3);
    check("left_first_shift", 32'(shift_log[s0] - base), 32'd2);
    check("left_last_shift", 32'(shift_log[s0 + 2] - base), 32'd4);
    check("left_model", 32'(sr), 32'h28);

    // Full right frame with gap: 81, len 0 (=8), gap 2, fill 1
    s0 = n_shift;
    r0 = n_right;
    start(8'h81, 1'b1, 4'd0, 4'd2, 1'b1, base);
    check("right_fill_out", 32'(sif.fill_out), 32'd1);
    wait_done(60, dcyc);
    check("right_done_cycle", 32'(dcyc - base), 32'd24);
    tick();
    check("right_shift_count", 32'(n_shift - s0), 32'd8);
    check("right_all_right", 32'(n_right - r0), 32'd8);
    check("right_spacing", 32'(shift_log[s0 + 1] - shift_log[s0]), 32'd3);
    check("right_last_shift", 32'(shift_log[s0 + 7] - base), 32'd23);
    check("right_model", 32'(sr), 32'hFF);
    check("right_fill_idle", 32'(sif.fill_out), 32'd0);

    // Clamp: len 15 gives exactly DW shifts
    s0 = n_shift;
    start(8'hFF, 1'b0, 4'd15, 4'd0, 1'b0, base);
    wait_done(40, dcyc);
    check("clamp_done_cycle", 32'(dcyc - base), 32'd10);
    tick();
    check("clamp_shift_count", 32'(n_shift - s0), 32'd8);
    check("clamp_model", 32'(sr), 32'h00);

    // Abort on the 2nd shift cycle of a len-5 frame
    s0 = n_shift;
    d0 = n_done;
    start(8'h0F, 1'b0, 4'd5, 4'd0, 1'b0, base);
    tick();
    tick();
    check("abort_in_shift", 32'(sif.shift_en), 32'd1);
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    check("abort_idle", 32'({sif.in_ready, sif.busy, sif.shift_en}), 32'b100);
    repeat (4) tick();
    check("abort_shift_count", 32'(n_shift - s0), 32'd2);
    check("abort_no_done", 32'(n_done - d0), 32'd0);

    // abort together with in_valid in IDLE still accepts the request
    sif.abort = 1'b1;
    start(8'h01, 1'b0, 4'd1, 4'd0, 1'b0, base);
    sif.abort = 1'b0;
    check("abort_idle_accept", 32'(sif.load_en), 32'd1);
    wait_done(10, dcyc);
    check("abort_idle_done", 32'(dcyc - base), 32'd3);
    tick();

    // Back-to-back frames with in_valid held high
    l0 = n_load;
    d0 = n_done;
    sif.in_data  = 8'h3C;
    sif.in_dir   = 1'b1;
    sif.in_len   = 4'd2;
    sif.in_gap   = 4'd0;
    sif.in_fill  = 1'b0;
    sif.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (n_load - l0 >= 2) break;
    end
    sif.in_valid = 1'b0;
    check("b2b_two_loads", 32'(n_load - l0), 32'd2);
    check("b2b_load_gap", 32'(load_log[l0 + 1] - done_log[d0]), 32'd2);
    wait_done(20, dcyc);
    tick();

    // Asynchronous reset during GAP
    d0 = n_done;
    start(8'h3C, 1'b0, 4'd4, 4'd3, 1'b1, base);
    tick();
    tick();
    check("rst_in_gap", 32'({sif.busy, sif.shift_en, sif.load_en}), 32'b100);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'({sif.busy, sif.shift_en, sif.fill_out, sif.done}), 32'd0);
    check("rst_mid_ready", 32'({sif.in_ready, sif.load_data}), {1'b1, 8'h00});
    #2;
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_no_done", 32'(n_done - d0), 32'd0);
    check("rst_stays_idle", 32'(sif.busy), 32'd0);

    check("dir_select_invariant", 32'(n_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
